// File: rtl/gray_ptr_counter.sv
// Up/down binary pointer with registered Gray output, plus a synchroniser and
// Gray-to-binary decoder for a pointer arriving from another clock domain.
module gray_ptr_counter #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  input  logic             inc_en,
  input  logic             dir_up,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             wrap,
  input  logic [WIDTH-1:0] remote_gray_in,
  output logic [WIDTH-1:0] remote_bin_out,
  output logic             remote_valid
);

  localparam int unsigned FILL_W = $clog2(SYNC_STAGES + 1);

  logic [WIDTH-1:0]  next_bin;
  logic              next_wrap;
  logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]  remote_dec;
  logic [FILL_W-1:0] fill_q;

  // Next local count: clear > load > count > hold
  always_comb begin
    next_bin  = bin_out;
    next_wrap = 1'b0;
    if (clear) begin
      next_bin = '0;
    end else if (load) begin
      next_bin = load_bin;
    end else if (inc_en) begin
      if (dir_up) begin
        next_bin  = bin_out + WIDTH'(1);
        next_wrap = &bin_out;
      end else begin
        next_bin  = bin_out - WIDTH'(1);
        next_wrap = ~|bin_out;
      end
    end
  end

  // Gray is encoded from the next value so the crossing signal comes straight off flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_out  <= '0;
      gray_out <= '0;
      wrap     <= 1'b0;
    end else begin
      bin_out  <= next_bin;
      gray_out <= next_bin ^ (next_bin >> 1);
      wrap     <= next_wrap;
    end
  end

  // Remote pointer synchroniser; raw Gray bits only, no logic ahead of stage 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= remote_gray_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Binary bit i is the XOR of all Gray bits at or above i
  always_comb begin
    remote_dec = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      remote_dec[i] = ^(sync_q[SYNC_STAGES-1] >> i);
    end
  end

  // Decoded output and fill tracking; valid rises on the edge that first carries synchronised data out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remote_bin_out <= '0;
      fill_q         <= '0;
      remote_valid   <= 1'b0;
    end else begin
      remote_bin_out <= remote_dec;
      if (fill_q != FILL_W'(SYNC_STAGES)) fill_q <= fill_q + FILL_W'(1);
      if (fill_q == FILL_W'(SYNC_STAGES)) remote_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gray_ptr_counter.sv
// Directed bench for gray_ptr_counter: arithmetic reference model checked every
// cycle, plus literal expectations for the key sequences.
module tb_gray_ptr_counter;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_bin = '0;
  logic         inc_en = 1'b0;
  logic         dir_up = 1'b0;
  logic [W-1:0] bin_out;
  logic [W-1:0] gray_out;
  logic         wrap;
  logic [W-1:0] remote_gray_in = '0;
  logic [W-1:0] remote_bin_out;
  logic         remote_valid;

  int total = 0;
  int bad = 0;

  // reference model state
  int m_bin, m_edges;
  bit m_wrap, m_step;
  int m_hist[$];
  int prev_gray = 0;
  int gray_tbl[16];

  gray_ptr_counter #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_bin(load_bin),
    .inc_en(inc_en), .dir_up(dir_up), .bin_out(bin_out), .gray_out(gray_out),
    .wrap(wrap), .remote_gray_in(remote_gray_in), .remote_bin_out(remote_bin_out),
    .remote_valid(remote_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Gray decode by search: the binary b whose code b^(b>>1) equals g
  function automatic int gray_dec(input int g);
    for (int b = 0; b < 16; b++) if ((b ^ (b >> 1)) == g) return b;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_bin <= 0; m_wrap <= 0; m_step <= 0; m_edges <= 0;
      m_hist.delete();
    end else begin
      m_wrap <= 0;
      m_step <= 0;
      if (clear) m_bin <= 0;
      else if (load) m_bin <= int'(load_bin);
      else if (inc_en) begin
        m_step <= 1;
        if (dir_up) begin
          m_bin  <= (m_bin + 1) % 16;
          m_wrap <= (m_bin == 15);
        end else begin
          m_bin  <= (m_bin + 15) % 16;
          m_wrap <= (m_bin == 0);
        end
      end
      if (m_edges < 3) m_edges <= m_edges + 1;
      m_hist.push_front(int'(remote_gray_in));
      if (m_hist.size() > 4) void'(m_hist.pop_back());
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_gray = 0;
    end else begin
      chk("bin", int'(bin_out), m_bin);
      chk("gray", int'(gray_out), m_bin ^ (m_bin >> 1));
      chk("wrap", int'(wrap), int'(m_wrap));
      chk("valid", int'(remote_valid), int'(m_edges >= 3));
      if (m_edges >= 3) chk("remote_bin", int'(remote_bin_out), gray_dec(m_hist[2]));
      if (m_step) chk("one_bit_step", $countones(int'(gray_out) ^ prev_gray), 1);
      prev_gray = int'(gray_out);
    end
  end

  task automatic step(input logic c, input logic l, input logic [W-1:0] lb,
                      input logic i, input logic u);
    @(negedge clk);
    #1;
    clear = c; load = l; load_bin = lb; inc_en = i; dir_up = u;
    @(posedge clk);
    #1;
  endtask

  task automatic rstep(input logic [W-1:0] g);
    @(negedge clk);
    #1;
    clear = 0; load = 0; inc_en = 0; remote_gray_in = g;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    gray_tbl = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

    // reset held from time 0, before any edge
    #1;
    chk("rst_bin", int'(bin_out), 0);
    chk("rst_gray", int'(gray_out), 0);
    chk("rst_wrap", int'(wrap), 0);
    chk("rst_valid", int'(remote_valid), 0);
    chk("rst_rbin", int'(remote_bin_out), 0);
    @(negedge clk);
    #1;
    rst_n = 1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("valid_edge%0d", e), int'(remote_valid), int'(e == 3));
    end

    // count up through a full wrap
    for (int k = 1; k <= 16; k++) begin
      step(0, 0, '0, 1, 1);
      chk($sformatf("up_bin%0d", k), int'(bin_out), k % 16);
      chk($sformatf("up_gray%0d", k), int'(gray_out), gray_tbl[k % 16]);
      chk($sformatf("up_wrap%0d", k), int'(wrap), int'(k == 16));
    end

    // count down from 0
    step(0, 0, '0, 1, 0);
    chk("dn_bin1", int'(bin_out), 15);
    chk("dn_gray1", int'(gray_out), 8);
    chk("dn_wrap1", int'(wrap), 1);
    step(0, 0, '0, 1, 0);
    chk("dn_bin2", int'(bin_out), 14);
    chk("dn_gray2", int'(gray_out), 9);
    chk("dn_wrap2", int'(wrap), 0);

    // load beats increment, clear beats load
    step(0, 1, 4'b1010, 1, 1);
    chk("ld_bin", int'(bin_out), 10);
    chk("ld_gray", int'(gray_out), 15);
    chk("ld_wrap", int'(wrap), 0);
    step(1, 1, 4'b0101, 1, 1);
    chk("clr_bin", int'(bin_out), 0);

    // jumps across the boundary by load do not wrap; counting does
    step(0, 1, 4'b1111, 0, 0);
    step(0, 1, 4'b0000, 0, 0);
    chk("ld_jump_wrap", int'(wrap), 0);
    step(0, 1, 4'b1111, 0, 0);
    step(0, 0, '0, 1, 1);
    chk("ld_then_up_wrap", int'(wrap), 1);
    step(0, 0, '0, 0, 0);
    chk("hold_wrap", int'(wrap), 0);

    // remote decode latency
    rstep(4'b1101);
    chk("r_lat1", int'(remote_bin_out), 0);
    step(0, 0, '0, 0, 0);
    chk("r_lat2", int'(remote_bin_out), 0);
    step(0, 0, '0, 0, 0);
    chk("r_lat3", int'(remote_bin_out), 9);

    // sweep every Gray code while the local counter runs
    for (int i = 0; i < 16; i++) begin
      rstep(W'(i ^ (i >> 1)));
      step(0, 0, '0, 1, 1);
      step(0, 0, '0, 1, 0);
      chk($sformatf("r_sweep%0d", i), int'(remote_bin_out), i);
    end

    // asynchronous reset mid-count at bin 0110
    step(1, 0, '0, 0, 0);
    for (int k = 0; k < 6; k++) step(0, 0, '0, 1, 1);
    chk("pre_rst_bin", int'(bin_out), 6);
    #2;
    rst_n = 0;
    #1;
    chk("arst_bin", int'(bin_out), 0);
    chk("arst_gray", int'(gray_out), 0);
    chk("arst_valid", int'(remote_valid), 0);
    chk("arst_rbin", int'(remote_bin_out), 0);
    @(negedge clk);
    #1;
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("post_rst_bin", int'(bin_out), 1);
    chk("post_rst_valid", int'(remote_valid), 0);
    step(0, 0, '0, 1, 1);
    step(0, 0, '0, 1, 1);
    chk("post_rst_bin3", int'(bin_out), 3);
    chk("post_rst_valid3", int'(remote_valid), 1);
    step(0, 0, '0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
